// File: rtl/rank_filter.sv
// rank_filter
//   Streaming rank-order filter. Collects a window of N samples, then returns
//   the k-th largest sample (k = RANK latched with the first sample of the
//   window, clamped to N-1). RANK=(N-1)/2 is the median, 0 the max, N-1 the min.
//   The result is found by RANK+1 successive max-scans over the entries that
//   have not yet been removed.
//
// Ports
//   CLK   in   1        clock, rising edge
//   RST   in   1        synchronous reset, active-high
//   DI    in   WIDTH    input sample
//   DSI   in   1        input valid
//   DRDY  out  1        input ready (accept on DSI && DRDY)
//   RANK  in   RW       rank select, sampled on the first accept of a window
//   DO    out  WIDTH    result sample (holds its last value after DSO falls)
//   DSO   out  1        result valid
//   DACK  in   1        result ready (consume on DSO && DACK)
//   BUSY  out  1        high while scanning or holding a result
//
// state | meaning
// LOAD  | accepting samples into mem[cnt]
// SCAN  | pass p = 0..rank_q, one unremoved entry per cycle, running maximum
// OUT   | DO valid, waiting for DACK
module rank_filter #(
  parameter int WIDTH  = 8,
  parameter int N      = 9,
  parameter int SIGNED = 0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [WIDTH-1:0]        DI,
  input  logic                    DSI,
  output logic                    DRDY,
  input  logic [$clog2(N)-1:0]    RANK,
  output logic [WIDTH-1:0]        DO,
  output logic                    DSO,
  input  logic                    DACK,
  output logic                    BUSY
);

  localparam int RW = $clog2(N);
  localparam logic [RW-1:0] LAST = RW'(N - 1);

  typedef enum logic [1:0] {LOAD, SCAN, OUT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] mem [N];
  logic [RW-1:0]    cnt, pass, rank_q, ptr, rem, idx, best_idx, win_idx;
  logic [N-1:0]     removed;
  logic [WIDTH-1:0] best, cur, win_val;
  logic             first, gt, take, accept, pass_done;

  assign accept    = DSI && DRDY;
  assign pass_done = (state == SCAN) && (rem == '0);

  // Next unremoved entry at or after ptr; lowest index wins, so each pass
  // visits exactly the N-pass survivors in ascending order.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!removed[i] && (RW'(i) >= ptr)) idx = RW'(i);
    end
  end

  // Strict compare keeps the earlier (lower-index) entry on ties.
  always_comb begin
    cur     = mem[idx];
    gt      = (SIGNED != 0) ? ($signed(cur) > $signed(best)) : (cur > best);
    take    = first || gt;
    win_val = take ? cur : best;
    win_idx = take ? idx : best_idx;
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= LOAD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (accept && (cnt == LAST)) state_nx = SCAN;
      SCAN:    if (pass_done && (pass == rank_q)) state_nx = OUT;
      OUT:     if (DACK) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_comb begin
    DRDY = (state == LOAD) && !RST;
    DSO  = (state == OUT);
    BUSY = (state == SCAN) || (state == OUT);
  end

  always_ff @(posedge CLK) begin
    if ((state == LOAD) && accept) mem[cnt] <= DI;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt      <= '0;
      pass     <= '0;
      rank_q   <= '0;
      ptr      <= '0;
      rem      <= '0;
      removed  <= '0;
      first    <= 1'b1;
      best     <= '0;
      best_idx <= '0;
      DO       <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (cnt == '0) rank_q <= (RANK > LAST) ? LAST : RANK;
            if (cnt == LAST) begin
              cnt   <= '0;
              pass  <= '0;
              ptr   <= '0;
              rem   <= LAST;
              first <= 1'b1;
            end else begin
              cnt <= cnt + RW'(1);
            end
          end
        end
        SCAN: begin
          if (rem == '0) begin
            if (pass == rank_q) begin
              DO <= win_val;
            end else begin
              removed[win_idx] <= 1'b1;
              pass  <= pass + RW'(1);
              rem   <= LAST - pass - RW'(1);
              ptr   <= '0;
              first <= 1'b1;
            end
          end else begin
            rem      <= rem - RW'(1);
            ptr      <= idx + RW'(1);
            first    <= 1'b0;
            best     <= win_val;
            best_idx <= win_idx;
          end
        end
        OUT: begin
          if (DACK) begin
            cnt     <= '0;
            pass    <= '0;
            removed <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rank_filter.sv
module tb_rank_filter;

  logic       CLK = 1'b0;
  logic       RST, DSI, DACK;
  logic [7:0] DI;
  logic [3:0] RANK;
  logic [7:0] do_u, do_s;
  logic       drdy_u, drdy_s, dso_u, dso_s, busy_u, busy_s;

  always #5 CLK = ~CLK;

  rank_filter #(.WIDTH(8), .N(9), .SIGNED(0)) u_uns (
    .CLK(CLK), .RST(RST), .DI(DI), .DSI(DSI), .DRDY(drdy_u), .RANK(RANK),
    .DO(do_u), .DSO(dso_u), .DACK(DACK), .BUSY(busy_u));

  rank_filter #(.WIDTH(8), .N(9), .SIGNED(1)) u_sgn (
    .CLK(CLK), .RST(RST), .DI(DI), .DSI(DSI), .DRDY(drdy_s), .RANK(RANK),
    .DO(do_s), .DSO(dso_s), .DACK(DACK), .BUSY(busy_s));

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int t0    = 0;

  typedef struct {
    logic [7:0] vu;
    logic [7:0] vs;
    int         lat;
  } exp_t;
  exp_t sb[$];

  logic [7:0] win [9];

  // Reference: full descending sort of the window, then index by clamped rank.
  function automatic logic [7:0] kth(input bit sgn, input int r);
    logic [7:0] a [9];
    logic [7:0] t;
    bit         lt;
    int         rr;
    a = win;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8 - i; j++) begin
        lt = sgn ? ($signed(a[j]) < $signed(a[j+1])) : (a[j] < a[j+1]);
        if (lt) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
      end
    end
    rr = (r > 8) ? 8 : r;
    return a[rr];
  endfunction

  function automatic int lat_of(input int r);
    int rr, s;
    rr = (r > 8) ? 8 : r;
    s  = 0;
    for (int p = 0; p <= rr; p++) s += 9 - p;
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input int r, input bit gaps, input bit expect_out);
    for (int i = 0; i < 9; i++) begin
      DI  = win[i];
      DSI = 1'b1;
      if (i == 0) begin
        RANK = r[3:0];
        check("drdy_load", 32'(drdy_u), 32'd1);
      end
      tick;
      RANK = 4'(r + 3);
      if (gaps && i < 8) begin
        DSI = 1'b0;
        DI  = 8'h33;
        tick;
      end
    end
    DSI = 1'b0;
    t0  = cyc;
    check("drdy_after_last", 32'(drdy_u), 32'd0);
    check("busy_scan", 32'(busy_u), 32'd1);
    if (expect_out) sb.push_back('{kth(1'b0, r), kth(1'b1, r), lat_of(r)});
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int   n;
    n    = 0;
    DACK = (hold == 0);
    while (!dso_u && n < 200) begin
      tick;
      n++;
    end
    check("dso_seen", 32'(dso_u), 32'd1);
    if (dso_u && sb.size() > 0) begin
      e = sb.pop_front();
      check("latency", 32'(cyc - t0), 32'(e.lat));
      check("do_unsigned", 32'(do_u), 32'(e.vu));
      check("do_signed", 32'(do_s), 32'(e.vs));
      check("dso_signed", 32'(dso_s), 32'd1);
      for (int k = 0; k < hold; k++) begin
        DSI = 1'b1;
        DI  = 8'(8'hC0 + k);
        tick;
        check("hold_dso", 32'(dso_u), 32'd1);
        check("hold_do", 32'(do_u), 32'(e.vu));
        check("hold_drdy", 32'(drdy_u), 32'd0);
      end
      DSI  = 1'b0;
      DACK = 1'b1;
      tick;
      check("dso_drop", 32'(dso_u), 32'd0);
      check("drdy_back", 32'(drdy_u), 32'd1);
      check("drdy_back_s", 32'(drdy_s), 32'd1);
      check("busy_idle", 32'(busy_u), 32'd0);
      check("do_keep", 32'(do_u), 32'(e.vu));
    end
  endtask

  initial begin
    int seen;
    RST  = 1'b1;
    DSI  = 1'b0;
    DACK = 1'b0;
    DI   = 8'h00;
    RANK = 4'd0;
    tick;
    tick;
    check("rst_drdy", 32'(drdy_u), 32'd0);
    check("rst_do", 32'(do_u), 32'd0);
    check("rst_dso", 32'(dso_u), 32'd0);
    check("rst_busy", 32'(busy_u), 32'd0);
    RST = 1'b0;
    #1;
    check("rel_drdy", 32'(drdy_u), 32'd1);

    // T1 median, back-to-back
    win = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
    send(4, 1'b0, 1'b1);
    collect(0);

    // T2 max, min, clamped rank
    send(0, 1'b0, 1'b1);  collect(0);
    send(8, 1'b0, 1'b1);  collect(0);
    send(15, 1'b0, 1'b1); collect(0);

    // T3 backpressure with junk samples offered during OUT
    send(4, 1'b0, 1'b1);
    collect(10);

    // T4 duplicates with gaps, then all-equal window for every rank
    win = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(4, 1'b1, 1'b1);
    collect(0);
    win = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
    for (int r = 0; r < 9; r++) begin
      send(r, 1'b0, 1'b1);
      collect(0);
    end

    // T5 signed vs unsigned interpretation of the same bits
    win = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h01, 8'hFE, 8'h02, 8'hFD, 8'h03};
    send(4, 1'b0, 1'b1);
    collect(0);

    // T6 reset during pass 2 of a median window
    win = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
    send(4, 1'b0, 1'b0);
    repeat (9 + 8 + 2) tick;
    check("pre_rst_dso", 32'(dso_u), 32'd0);
    RST = 1'b1;
    #1;
    check("rst_hold_drdy", 32'(drdy_u), 32'd0);
    tick;
    RST = 1'b0;
    #1;
    check("abort_drdy", 32'(drdy_u), 32'd1);
    check("abort_do", 32'(do_u), 32'd0);
    check("abort_dso", 32'(dso_u), 32'd0);
    check("abort_busy", 32'(busy_u), 32'd0);
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      tick;
      if (dso_u || dso_s) seen++;
    end
    check("abort_no_dso", 32'(seen), 32'd0);
    send(4, 1'b0, 1'b1);
    collect(0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
